aes_round_controller: RTL

//  Sequences an iterative AES-128 encryption over one shared combinational round

---
 rtl/aes_round_controller_if.sv | 26 ++
 rtl/aes_round_controller.sv | 109 ++++++++++
 2 files changed

// File: rtl/aes_round_controller_if.sv
// Stream, key-store and round-datapath signals around the AES round controller.
// slave: the controller itself; master: the surrounding system and datapath.
interface aes_round_controller_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   round_num;
  logic [127:0] round_key;
  logic [127:0] dp_state_out;
  logic [127:0] dp_state_in;
  logic         last_round;
  logic         busy;

  modport master (
    output in_valid, data_in, out_ready, round_key, dp_state_in,
    input  in_ready, out_valid, data_out, round_num, dp_state_out, last_round, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready, round_key, dp_state_in,
    output in_ready, out_valid, data_out, round_num, dp_state_out, last_round, busy
  );
endinterface

// File: rtl/aes_round_controller.sv
// Iterative AES encryption sequencer: owns the state register and round counter and
// steps one shared round datapath through NUM_ROUNDS rounds, one round per clock.
//
//   state | meaning
//   IDLE  | ready for a block; initial AddRoundKey applied on acceptance
//   ROUND | one datapath round per cycle, rounds 1..NUM_ROUNDS
//   DONE  | ciphertext presented on data_out until out_ready
module aes_round_controller #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic                   clk_i,
  input logic                   n_rst_i,
  aes_round_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS);

  state_e       state_q;
  logic [127:0] state_reg_q;
  logic [127:0] data_out_q;
  logic [3:0]   round_cnt_q;
  logic [3:0]   round_num_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         last_round_q;

  logic [3:0]   round_cnt_d;
  logic         last_round_d;

  // The counter is 0 in IDLE, so the same increment serves both entry into ROUND
  // and advancing within it.
  always_comb begin
    round_cnt_d  = round_cnt_q + 4'd1;
    last_round_d = (round_cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q      <= IDLE;
      state_reg_q  <= '0;
      data_out_q   <= '0;
      round_cnt_q  <= '0;
      round_num_q  <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      last_round_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg_q  <= bus.data_in ^ bus.round_key;
            round_cnt_q  <= round_cnt_d;
            round_num_q  <= round_cnt_d;
            last_round_q <= last_round_d;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ROUND;
          end
        end

        ROUND: begin
          state_reg_q <= bus.dp_state_in;
          if (last_round_q) begin
            data_out_q   <= bus.dp_state_in;
            out_valid_q  <= 1'b1;
            round_num_q  <= '0;
            last_round_q <= 1'b0;
            state_q      <= DONE;
          end else begin
            round_cnt_q  <= round_cnt_d;
            round_num_q  <= round_cnt_d;
            last_round_q <= last_round_d;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            round_cnt_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.data_out     = data_out_q;
  assign bus.round_num    = round_num_q;
  assign bus.last_round   = last_round_q;
  assign bus.busy         = busy_q;
  assign bus.dp_state_out = state_reg_q;

endmodule
